mini_src_datapath: RTL and testbench
====================================

MINI_SRC_DATAPATH -- requirements
Module: mini_src_datapath

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: Clock (in, 1) rising-edge clock; Clear (in, 1) reset, sampled on the Clock rising edge, active when 0.
REQ-002 The block SHALL have these register-load strobes, all in, 1 bit, acting on the Clock rising edge: PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort (load the output-port register), Yin.
REQ-003 The block SHALL have these bus-drive selects, all in, 1 bit: PCout, HIout, LOout, ZHighout, ZLowout, InPort (drive In_data), MDRout, Cout (drive the sign-extended IR constant).
REQ-004 The block SHALL have these register-file controls, all in, 1 bit: Gra, Grb and Grc (select the IR Ra, Rb or Rc field), Rin (write selected register), Rout (read selected register), BAout (base-address read, with R0 reading as 0).
REQ-005 The block SHALL have these memory controls, all in, 1 bit: Read (MDR input mux selects memory) and Write (store MDR to memory[MAR]).
REQ-006 The block SHALL have IncPC (in, 1), which increments the PC.
REQ-007 The block SHALL have CON_In (in, 1), which latches the branch condition, and CON_Out (out, 1), which is the latched condition.
REQ-008 The block SHALL have OP (in, 5), which is the ALU operation select.
REQ-009 The block SHALL have GLR (in, 1), which forces the register-file write target to R15 (link register).
REQ-010 The block SHALL have In_data (in, 32), the input-port data, and Out_data (out, 32), the output-port register value; both come after GLR in port order.

Function
REQ-011 Internal state SHALL be: PC, IR, MAR, MDR, Y, HI, LO, OutPort register (each 32-bit), Z (64-bit), R0..R15 (32-bit), the CON flip-flop, and a 512x32 RAM named ram_instance with array memory.
REQ-012 The 32-bit bus SHALL carry the value of the single asserted out-select; with none asserted the bus SHALL be 0; with several asserted, priority SHALL be Rout/BAout > PCout > MDRout > ZHighout > ZLowout > HIout > LOout > InPort > Cout.
REQ-013 The IR fields SHALL be: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C2 [20:19], C = [18:0] sign-extended to 32 bits.
REQ-014 The register select SHALL be the OR of the decoded Gra/Grb/Grc fields; Rin writes the bus into the selected register(s), or into R15 only when GLR=1.
REQ-015 BAout SHALL drive 0 when R0 is selected, and the register value otherwise.
REQ-016 The MAR SHALL load the bus when MARin is asserted.
REQ-017 The MDR SHALL load memory[MAR[8:0]] when Read=1 and the bus when Read=0, on MDRin.
REQ-018 Memory read SHALL be combinational; Write SHALL store MDR into memory[MAR[8:0]] on the clock edge.
REQ-019 PC update SHALL follow: PCin loads the bus; IncPC loads PC+1 (mod 2^32); if both are asserted, PCin wins.
REQ-020 The ALU SHALL take A=Y and B=bus, with Z computed combinationally and loaded per half by ZHighin/ZLowin.
REQ-021 ALU operations by OP: 00011 add; 00100 sub; 00101 shr; 00110 shra; 00111 shl; 01000 ror; 01001 rol; 01010/01101 and; 01011/01110 or; 10000 signed mul (64-bit product); 01111 signed div (ZLow=quotient, ZHigh=remainder); 10001 neg B; 10010 not B.
REQ-022 All other OP values SHALL perform add.
REQ-023 Shift and rotate amounts SHALL be bus[4:0].
REQ-024 Non-mul/div results SHALL set ZHigh=0; add and sub wrap mod 2^32.
REQ-025 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = Y.
REQ-026 The CON flip-flop SHALL load on CON_In from the bus value by C2: 00 bus==0, 01 bus!=0, 10 bus[31]==0, 11 bus[31]==1.
REQ-027 Instruction fetch SHALL be: T0 (PCout, MARin, Read, MDRin held 2 cycles) fetches mem[PC] into MDR; T1 (IncPC, 1 cycle) gives PC+1; T2 (MDRout, IRin) gives IR=MDR.
REQ-028 jr Ra SHALL execute as Gra, Rout, PCin, giving PC=R[Ra].

Reset
REQ-029 With Clear=0 at a rising edge, PC, IR, MAR, MDR, Y, Z, HI, LO, R0..R15, CON and OutPort SHALL be set to 0.
REQ-030 Memory contents SHALL NOT be altered by reset.
REQ-031 Reset SHALL override all simultaneous loads and abort any in-progress sequence.

Verification
REQ-032 Reset: Clear=0 for 1 edge -> PC=0, IR=0, R2=0, CON_Out=0.
REQ-033 jr: memory[0]=0xA1000000, R2=0x00000005, Clear=1, run T0-T3 -> IR=0xA1000000, PC=1 after T1, PC=0x00000005 after T3.
REQ-034 ALU: Y=7 and bus=R(Rb)=0xFFFFFFFD (-3) -> mul gives Z=0xFFFFFFFF_FFFFFFEB; div gives ZLow=0xFFFFFFFE, ZHigh=1; add gives ZLow=4, ZHigh=0.
REQ-035 Store/load: MAR=0x1F0, MDR=0xDEADBEEF, Write -> memory[0x1F0]=0xDEADBEEF; then Read+MDRin -> MDR=0xDEADBEEF.
REQ-036 Branch: IR C2=00, R2=0, Gra+Rout+CON_In -> CON_Out=1; with C2=11 and R2=0x80000000 -> CON_Out=1; with C2=01 and R2=0 -> CON_Out=0.
REQ-037 BAout/GLR: Ra=R0 with R0 written 9, BAout -> bus=0; GLR+Rin with bus=0x20 -> R15=0x20 and the IR-selected register unchanged.

Source files
------------

// File: rtl/mini_src_datapath.sv
// Single-bus SRC-style datapath: register file, PC/IR/MAR/MDR, Y/Z ALU path,
// HI/LO, I/O port registers, branch-condition flop and a 512-word data RAM.
module mini_src_ram (
    input  logic        clk,
    input  logic        we,
    input  logic [8:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] memory [512];

    always_ff @(posedge clk) begin
        if (we) memory[addr] <= wdata;
    end

    assign rdata = memory[addr];
endmodule

module mini_src_datapath (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        ZHighin,
    input  logic        ZLowin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        OutPort,
    input  logic        Yin,
    input  logic        PCout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        ZHighout,
    input  logic        ZLowout,
    input  logic        InPort,
    input  logic        MDRout,
    input  logic        Cout,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        Read,
    input  logic        Write,
    input  logic        IncPC,
    input  logic        CON_In,
    output logic        CON_Out,
    input  logic [4:0]  OP,
    input  logic        GLR,
    input  logic [31:0] In_data,
    output logic [31:0] Out_data
);
    logic [31:0] pc_reg, ir_reg, mar_reg, mdr_reg, y_reg, hi_reg, lo_reg, out_reg;
    logic [63:0] z_reg;
    logic        con_reg;
    logic [31:0] reg_file [16];
    logic [31:0] bus;
    logic [31:0] mem_rdata;
    logic [31:0] c_ext;
    logic [15:0] reg_sel, reg_wr;
    logic [31:0] reg_rd;
    logic [63:0] alu;
    logic        con_next;
    logic        unused_bits;

    // Opcode bits and the upper MAR bits are decoded elsewhere or not at all.
    assign unused_bits = ^{ir_reg[31:27], mar_reg[31:9]};

    assign c_ext = {{13{ir_reg[18]}}, ir_reg[18:0]};

    always_comb begin
        reg_sel = '0;
        if (Gra) reg_sel = reg_sel | (16'b1 << ir_reg[26:23]);
        if (Grb) reg_sel = reg_sel | (16'b1 << ir_reg[22:19]);
        if (Grc) reg_sel = reg_sel | (16'b1 << ir_reg[18:15]);
    end

    assign reg_wr = Rin ? (GLR ? 16'h8000 : reg_sel) : 16'h0000;

    // BAout treats R0 as a hard zero so it can serve as "no base register".
    always_comb begin
        reg_rd = '0;
        for (int i = 0; i < 16; i++) begin
            if (reg_sel[i] && !(BAout && i == 0)) reg_rd = reg_rd | reg_file[i];
        end
    end

    always_comb begin
        if (Rout || BAout) bus = reg_rd;
        else if (PCout)    bus = pc_reg;
        else if (MDRout)   bus = mdr_reg;
        else if (ZHighout) bus = z_reg[63:32];
        else if (ZLowout)  bus = z_reg[31:0];
        else if (HIout)    bus = hi_reg;
        else if (LOout)    bus = lo_reg;
        else if (InPort)   bus = In_data;
        else if (Cout)     bus = c_ext;
        else               bus = '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_regs
            logic [31:0] r_reg;
            always_ff @(posedge Clock) begin
                if (!Clear)          r_reg <= '0;
                else if (reg_wr[gi]) r_reg <= bus;
            end
            assign reg_file[gi] = r_reg;
        end
    endgenerate

    // ALU: A is always Y, B is whatever currently drives the bus.
    logic [31:0] alu_a, alu_b, sra_res, div_b, quo, rem;
    logic [4:0]  sh;
    logic [5:0]  sh_inv;
    logic signed [63:0] prod;

    assign alu_a   = y_reg;
    assign alu_b   = bus;
    assign sh      = bus[4:0];
    assign sh_inv  = 6'd32 - {1'b0, sh};
    assign sra_res = $signed(alu_a) >>> sh;
    assign prod    = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
    assign div_b   = (alu_b == 32'd0) ? 32'd1 : alu_b;
    assign quo     = $signed(alu_a) / $signed(div_b);
    assign rem     = $signed(alu_a) % $signed(div_b);

    always_comb begin
        alu = {32'd0, alu_a + alu_b};
        case (OP)
            5'b00100: alu = {32'd0, alu_a - alu_b};
            5'b00101: alu = {32'd0, alu_a >> sh};
            5'b00110: alu = {32'd0, sra_res};
            5'b00111: alu = {32'd0, alu_a << sh};
            5'b01000: alu = {32'd0, (alu_a >> sh) | (alu_a << sh_inv)};
            5'b01001: alu = {32'd0, (alu_a << sh) | (alu_a >> sh_inv)};
            5'b01010, 5'b01101: alu = {32'd0, alu_a & alu_b};
            5'b01011, 5'b01110: alu = {32'd0, alu_a | alu_b};
            5'b10000: alu = prod;
            5'b01111: alu = (alu_b == 32'd0) ? {alu_a, 32'hFFFF_FFFF} : {rem, quo};
            5'b10001: alu = {32'd0, 32'd0 - alu_b};
            5'b10010: alu = {32'd0, ~alu_b};
            default:  alu = {32'd0, alu_a + alu_b};
        endcase
    end

    always_comb begin
        case (ir_reg[20:19])
            2'b00:   con_next = (bus == 32'd0);
            2'b01:   con_next = (bus != 32'd0);
            2'b10:   con_next = ~bus[31];
            default: con_next = bus[31];
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            pc_reg  <= '0;
            ir_reg  <= '0;
            mar_reg <= '0;
            mdr_reg <= '0;
            y_reg   <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
            out_reg <= '0;
            z_reg   <= '0;
            con_reg <= 1'b0;
        end else begin
            if (PCin)       pc_reg <= bus;
            else if (IncPC) pc_reg <= pc_reg + 32'd1;
            if (IRin)    ir_reg  <= bus;
            if (MARin)   mar_reg <= bus;
            if (MDRin)   mdr_reg <= Read ? mem_rdata : bus;
            if (Yin)     y_reg   <= bus;
            if (HIin)    hi_reg  <= bus;
            if (LOin)    lo_reg  <= bus;
            if (OutPort) out_reg <= bus;
            if (ZHighin) z_reg[63:32] <= alu[63:32];
            if (ZLowin)  z_reg[31:0]  <= alu[31:0];
            if (CON_In)  con_reg <= con_next;
        end
    end

    // Stores are suppressed during reset so Clear cannot corrupt memory.
    mini_src_ram ram_instance (
        .clk   (Clock),
        .we    (Write & Clear),
        .addr  (mar_reg[8:0]),
        .wdata (mdr_reg),
        .rdata (mem_rdata)
    );

    assign CON_Out  = con_reg;
    assign Out_data = out_reg;
endmodule

// File: tb/tb_mini_src_datapath.sv
// Directed and randomized checks of mini_src_datapath against a behavioural model.
module tb_mini_src_datapath;
    logic clk = 1'b0;
    logic Clear;
    logic PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin;
    logic PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR;
    logic CON_Out;
    logic [4:0]  OP;
    logic [31:0] In_data, Out_data;

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mini_src_datapath dut (
        .Clock(clk), .Clear(Clear), .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin),
        .ZHighin(ZHighin), .ZLowin(ZLowin), .MARin(MARin), .MDRin(MDRin), .OutPort(OutPort),
        .Yin(Yin), .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout),
        .ZLowout(ZLowout), .InPort(InPort), .MDRout(MDRout), .Cout(Cout), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Read(Read),
        .Write(Write), .IncPC(IncPC), .CON_In(CON_In), .CON_Out(CON_Out), .OP(OP),
        .GLR(GLR), .In_data(In_data), .Out_data(Out_data)
    );

    task automatic idle();
        {PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin} = '0;
        {PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR} = '0;
        OP = 5'b00011;
        In_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic bus_in(input logic [31:0] v);
        InPort = 1'b1;
        In_data = v;
    endtask

    task automatic load_ir(input logic [31:0] v);
        bus_in(v); IRin = 1'b1; step();
    endtask

    task automatic write_ra(input logic [31:0] v);
        bus_in(v); Gra = 1'b1; Rin = 1'b1; step();
    endtask

    task automatic mem_store(input logic [31:0] addr, input logic [31:0] data);
        bus_in(addr); MARin = 1'b1; step();
        bus_in(data); MDRin = 1'b1; step();
        Write = 1'b1; step();
    endtask

    // Reference ALU written from the arithmetic meaning of each operation.
    function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b);
        int          iy, ib, n;
        longint      sy, sb, uy, p, d, q;
        logic [63:0] yy;
        logic [31:0] lo, hi;
        iy = y; ib = b; sy = iy; sb = ib; uy = {32'd0, y};
        n = int'(b[4:0]);
        d = longint'(1) << n;
        lo = '0; hi = '0;
        case (op)
            5'd4:  lo = 32'(sy - sb);
            5'd5:  lo = 32'(uy / d);
            5'd6: begin
                q = sy / d;
                if (sy < 0 && (sy % d) != 0) q = q - 1;
                lo = 32'(q);
            end
            5'd7:  lo = 32'(uy * d);
            5'd8: begin yy = {y, y}; yy = yy >> n; lo = yy[31:0]; end
            5'd9: begin yy = {y, y}; yy = yy << n; lo = yy[63:32]; end
            5'd10, 5'd13: lo = y & b;
            5'd11, 5'd14: lo = y | b;
            5'd16: begin p = sy * sb; return p; end
            5'd15: begin
                if (ib == 0) begin lo = 32'hFFFF_FFFF; hi = y; end
                else begin lo = 32'(iy / ib); hi = 32'(iy % ib); end
            end
            5'd17: lo = 32'(-sb);
            5'd18: lo = 32'(64'hFFFF_FFFF - {32'd0, b});
            default: lo = 32'(sy + sb);
        endcase
        return {hi, lo};
    endfunction

    logic [4:0] op_list [19] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                 5'd13, 5'd14, 5'd16, 5'd15, 5'd17, 5'd18, 5'd0, 5'd31, 5'd12, 5'd1};

    initial begin
        logic [31:0] ry, rb;
        logic [4:0]  rop;
        idle();
        // Reset with conflicting loads asserted.
        Clear = 1'b0;
        bus_in(32'h55); PCin = 1'b1; Yin = 1'b1; IRin = 1'b1;
        step();
        check("rst_pc", {32'd0, dut.pc_reg}, 64'd0);
        check("rst_ir", {32'd0, dut.ir_reg}, 64'd0);
        check("rst_r2", {32'd0, dut.reg_file[2]}, 64'd0);
        check("rst_con", {63'd0, CON_Out}, 64'd0);
        check("rst_out", {32'd0, Out_data}, 64'd0);
        check("rst_z", dut.z_reg, 64'd0);
        Clear = 1'b1;

        // jr fetch/execute sequence.
        mem_store(32'd0, 32'hA100_0000);
        load_ir(32'h0100_0000);
        write_ra(32'd5);
        check("r2_load", {32'd0, dut.reg_file[2]}, 64'd5);
        for (int i = 0; i < 2; i++) begin
            PCout = 1'b1; MARin = 1'b1; Read = 1'b1; MDRin = 1'b1; step();
        end
        check("t0_mdr", {32'd0, dut.mdr_reg}, 64'hA100_0000);
        IncPC = 1'b1; step();
        check("t1_pc", {32'd0, dut.pc_reg}, 64'd1);
        MDRout = 1'b1; IRin = 1'b1; step();
        check("t2_ir", {32'd0, dut.ir_reg}, 64'hA100_0000);
        Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; step();
        check("t3_pc", {32'd0, dut.pc_reg}, 64'd5);

        // PCin beats IncPC.
        bus_in(32'h1234); PCin = 1'b1; IncPC = 1'b1; step();
        check("pc_prio", {32'd0, dut.pc_reg}, 64'h1234);
        bus_in(32'hFFFF_FFFF); PCin = 1'b1; step();
        IncPC = 1'b1; step();
        check("pc_wrap", {32'd0, dut.pc_reg}, 64'd0);

        // Directed ALU with bus = R(Rb) = -3 and Y = 7.
        load_ir(32'h0018_0000);
        bus_in(32'hFFFF_FFFD); Grb = 1'b1; Rin = 1'b1; step();
        bus_in(32'd7); Yin = 1'b1; step();
        Grb = 1'b1; Rout = 1'b1; OP = 5'b10000; ZHighin = 1'b1; ZLowin = 1'b1; step();
        check("mul", dut.z_reg, 64'hFFFF_FFFF_FFFF_FFEB);
        Grb = 1'b1; Rout = 1'b1; OP = 5'b01111; ZHighin = 1'b1; ZLowin = 1'b1; step();
        check("div", dut.z_reg, 64'h0000_0001_FFFF_FFFE);
        Grb = 1'b1; Rout = 1'b1; OP = 5'b00011; ZLowin = 1'b1; step();
        check("zlow_only", dut.z_reg, 64'h0000_0001_0000_0004);
        Grb = 1'b1; Rout = 1'b1; OP = 5'b00011; ZHighin = 1'b1; ZLowin = 1'b1; step();
        check("add", dut.z_reg, 64'h0000_0000_0000_0004);
        ZLowout = 1'b1; OutPort = 1'b1; step();
        check("zlow_out", {32'd0, Out_data}, 64'd4);

        // Randomized ALU: bus driven from the input port.
        for (int i = 0; i < 60; i++) begin
            ry  = $urandom();
            rb  = $urandom();
            rop = op_list[$urandom_range(0, 18)];
            if (i % 9 == 0) rb = 32'd0;
            if (ry == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            bus_in(ry); Yin = 1'b1; step();
            bus_in(rb); OP = rop; ZHighin = 1'b1; ZLowin = 1'b1; step();
            check($sformatf("alu_op%0d", rop), dut.z_reg, alu_model(rop, ry, rb));
        end

        // Store / load, including MAR bits above the RAM address being ignored.
        mem_store(32'h1F0, 32'hDEAD_BEEF);
        check("mem_store", {32'd0, dut.ram_instance.memory[9'h1F0]}, 64'hDEAD_BEEF);
        bus_in(32'd0); MDRin = 1'b1; step();
        Read = 1'b1; MDRin = 1'b1; step();
        check("mem_load", {32'd0, dut.mdr_reg}, 64'hDEAD_BEEF);
        bus_in(32'h3F0); MARin = 1'b1; step();
        Read = 1'b1; MDRin = 1'b1; step();
        check("mar_wrap", {32'd0, dut.mdr_reg}, 64'hDEAD_BEEF);

        // Branch condition.
        load_ir(32'h0100_0000);
        write_ra(32'd0);
        Gra = 1'b1; Rout = 1'b1; CON_In = 1'b1; step();
        check("con_eq0", {63'd0, CON_Out}, 64'd1);
        load_ir(32'h0118_0000);
        write_ra(32'h8000_0000);
        Gra = 1'b1; Rout = 1'b1; CON_In = 1'b1; step();
        check("con_neg", {63'd0, CON_Out}, 64'd1);
        load_ir(32'h0110_0000);
        Gra = 1'b1; Rout = 1'b1; CON_In = 1'b1; step();
        check("con_pos", {63'd0, CON_Out}, 64'd0);
        load_ir(32'h0108_0000);
        write_ra(32'd0);
        Gra = 1'b1; Rout = 1'b1; CON_In = 1'b1; step();
        check("con_ne0", {63'd0, CON_Out}, 64'd0);

        // BAout and GLR.
        load_ir(32'h0000_0000);
        write_ra(32'd9);
        Gra = 1'b1; BAout = 1'b1; OutPort = 1'b1; step();
        check("baout_r0", {32'd0, Out_data}, 64'd0);
        Gra = 1'b1; Rout = 1'b1; OutPort = 1'b1; step();
        check("rout_r0", {32'd0, Out_data}, 64'd9);
        bus_in(32'h20); Gra = 1'b1; Rin = 1'b1; GLR = 1'b1; step();
        check("glr_r15", {32'd0, dut.reg_file[15]}, 64'h20);
        check("glr_r0", {32'd0, dut.reg_file[0]}, 64'd9);

        // Bus priority and the idle bus.
        PCout = 1'b1; MDRout = 1'b1; InPort = 1'b1; In_data = 32'h77; OutPort = 1'b1; step();
        check("prio_pc", {32'd0, Out_data}, {32'd0, dut.pc_reg});
        MDRout = 1'b1; InPort = 1'b1; In_data = 32'h77; OutPort = 1'b1; step();
        check("prio_mdr", {32'd0, Out_data}, 64'hDEAD_BEEF);
        OutPort = 1'b1; step();
        check("bus_idle", {32'd0, Out_data}, 64'd0);
        load_ir(32'h0004_0000);
        Cout = 1'b1; OutPort = 1'b1; step();
        check("c_sext", {32'd0, Out_data}, 64'hFFFC_0000);

        // Reset mid-run must not write memory.
        bus_in(32'h1F0); MARin = 1'b1; step();
        bus_in(32'h1234_5678); MDRin = 1'b1; step();
        Clear = 1'b0; Write = 1'b1; IncPC = 1'b1; step();
        Clear = 1'b1;
        check("rst_mem", {32'd0, dut.ram_instance.memory[9'h1F0]}, 64'hDEAD_BEEF);
        check("rst2_pc", {32'd0, dut.pc_reg}, 64'd0);
        check("rst2_r15", {32'd0, dut.reg_file[15]}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
